// File: rtl/lut_cfg_pkg.sv
// Shared types and defaults for the LUT table loader and its RAM.
// State encoding, default geometry and the beat-count helpers live here
// so the loader and the RAM always agree on table layout.
package lut_cfg_pkg;

  // Loader FSM states
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    ARMED   = 2'd2,
    ERROR   = 2'd3
  } lut_state_t;

  // Default table geometry: 64 one-bit entries loaded in byte-wide beats
  localparam int DEF_IN_BITS  = 6;
  localparam int DEF_OUT_BITS = 1;
  localparam int DEF_CFG_W    = 8;

  // Number of config beats needed to fill a whole table
  function automatic int calc_nbeats(input int in_bits, input int out_bits, input int cfg_w);
    return ((1 << in_bits) * out_bits) / cfg_w;
  endfunction

  // Width of a beat index; kept at least one bit for single-beat tables
  function automatic int calc_beat_w(input int nbeats);
    return (nbeats > 1) ? $clog2(nbeats) : 1;
  endfunction

endpackage

// File: rtl/lut_table_ram.sv
// Table storage for the LUT loader: DEPTH x OUT_BITS distributed RAM.
// Written a whole config beat at a time, read one entry at a time through
// a registered output. The storage is a flat bit vector so that beat k,
// bit j lands on flat bit k*CFG_W+j and entry e occupies bits
// e*OUT_BITS .. e*OUT_BITS+OUT_BITS-1, regardless of how beats and entries
// straddle each other.
module lut_table_ram
  import lut_cfg_pkg::*;
#(
  parameter int IN_BITS  = DEF_IN_BITS,
  parameter int OUT_BITS = DEF_OUT_BITS,
  parameter int CFG_W    = DEF_CFG_W,
  parameter int BEAT_W   = calc_beat_w(calc_nbeats(IN_BITS, OUT_BITS, CFG_W))
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [BEAT_W-1:0]   wr_beat,
  input  logic [CFG_W-1:0]    wr_data,
  input  logic                rd_en,
  input  logic [IN_BITS-1:0]  rd_addr,
  output logic [OUT_BITS-1:0] rd_data
);

  localparam int DEPTH    = 1 << IN_BITS;
  localparam int TOTAL_W  = DEPTH * OUT_BITS;

  logic [TOTAL_W-1:0] mem;

  // Beat-wide write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[int'(wr_beat) * CFG_W +: CFG_W] <= wr_data;
    end
  end

  // Registered single-entry read; a same-edge write is not visible yet
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[int'(rd_addr) * OUT_BITS +: OUT_BITS];
    end
  end

endmodule

// File: rtl/lut_table_loader.sv
// Writer side of the LUT neuron tables.
// Accepts a streamed truth table over the cfg port, checks that it arrives
// as exactly NBEATS beats with cfg_last on the final one, and serves
// one-cycle-latency lookups once a complete table is held. A new beat in
// ARMED starts a reload; any lookup accepted on that same edge still sees
// the old table because the RAM read is registered before the write lands.
// Optional feature macro: LUT_READBACK_EN adds rb_req/rb_valid/rb_data,
// which stream the whole table out one entry per cycle.
module lut_table_loader
  import lut_cfg_pkg::*;
#(
  parameter int IN_BITS  = DEF_IN_BITS,
  parameter int OUT_BITS = DEF_OUT_BITS,
  parameter int CFG_W    = DEF_CFG_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CFG_W-1:0]    cfg_data,
  input  logic                cfg_last,
  input  logic                lk_valid,
  output logic                lk_ready,
  input  logic [IN_BITS-1:0]  lk_addr,
  output logic                res_valid,
  output logic [OUT_BITS-1:0] res_data,
  output logic                table_ok,
`ifdef LUT_READBACK_EN
  input  logic                rb_req,
  output logic                rb_valid,
  output logic [OUT_BITS-1:0] rb_data,
`endif
  output logic                cfg_err
);

  localparam int DEPTH  = 1 << IN_BITS;
  localparam int NBEATS = calc_nbeats(IN_BITS, OUT_BITS, CFG_W);
  localparam int BEAT_W = calc_beat_w(NBEATS);
  localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(NBEATS - 1);
  localparam logic [IN_BITS-1:0] LAST_ADDR = IN_BITS'(DEPTH - 1);

  lut_state_t          state;
  lut_state_t          state_next;
  logic [BEAT_W-1:0]   cnt;
  logic [BEAT_W-1:0]   cnt_next;
  logic [BEAT_W-1:0]   beat_idx;
  logic                cfg_fire;
  logic                lk_fire;
  logic                rd_en;
  logic [IN_BITS-1:0]  rd_addr;
  logic [OUT_BITS-1:0] ram_rd_data;

  logic                rb_start;
  logic                rb_active;
  logic                rb_busy_next;
  logic [IN_BITS-1:0]  rb_cnt;

  // Handshakes and next-state decode for an accepted config beat
  always_comb begin
    cfg_fire   = cfg_valid & cfg_ready;
    lk_fire    = lk_valid & lk_ready;
    beat_idx   = (state == LOADING) ? cnt : '0;
    state_next = state;
    cnt_next   = cnt;
    if (cfg_fire) begin
      if (beat_idx == LAST_BEAT) begin
        state_next = cfg_last ? ARMED : ERROR;
        cnt_next   = '0;
      end else if (cfg_last) begin
        state_next = ERROR;
        cnt_next   = '0;
      end else begin
        state_next = LOADING;
        cnt_next   = beat_idx + 1'b1;
      end
    end
  end

`ifdef LUT_READBACK_EN
  // Readback start and continuation; a request that coincides with a beat
  // or a lookup is dropped so the single RAM read port is never contended
  always_comb begin
    rb_start     = rb_req & (state == ARMED) & ~rb_active & ~cfg_fire & ~lk_fire;
    rb_busy_next = rb_start | (rb_active & (rb_cnt != LAST_ADDR));
  end

  // Readback address counter and valid strobe, aligned with RAM output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_active <= 1'b0;
      rb_cnt    <= '0;
      rb_valid  <= 1'b0;
    end else if (rb_start) begin
      rb_active <= 1'b1;
      rb_cnt    <= IN_BITS'(1);
      rb_valid  <= 1'b1;
    end else if (rb_active) begin
      rb_valid  <= 1'b1;
      rb_cnt    <= rb_cnt + 1'b1;
      if (rb_cnt == LAST_ADDR) begin
        rb_active <= 1'b0;
      end
    end else begin
      rb_valid  <= 1'b0;
    end
  end

  assign rb_data = ram_rd_data;
`else
  assign rb_start     = 1'b0;
  assign rb_active    = 1'b0;
  assign rb_busy_next = 1'b0;
  assign rb_cnt       = '0;
`endif

  // RAM read port is shared between lookups and readback
  always_comb begin
    rd_en   = lk_fire | rb_start | rb_active;
    rd_addr = lk_addr;
    if (rb_active) begin
      rd_addr = rb_cnt;
    end else if (rb_start) begin
      rd_addr = '0;
    end
  end

  // Loader FSM with registered handshake and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      cnt       <= '0;
      cfg_ready <= 1'b0;
      lk_ready  <= 1'b0;
      res_valid <= 1'b0;
      table_ok  <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      cfg_ready <= ~rb_busy_next;
      lk_ready  <= (state_next == ARMED) & ~rb_busy_next;
      table_ok  <= (state_next == ARMED);
      res_valid <= lk_fire;
      if (cfg_fire) begin
        cfg_err <= (state_next == ERROR);
      end
    end
  end

  assign res_data = ram_rd_data;

  lut_table_ram #(
    .IN_BITS  (IN_BITS),
    .OUT_BITS (OUT_BITS),
    .CFG_W    (CFG_W),
    .BEAT_W   (BEAT_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (cfg_fire),
    .wr_beat (beat_idx),
    .wr_data (cfg_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (ram_rd_data)
  );

endmodule

// File: tb/tb_lut_table_loader.sv
// Directed bench for lut_table_loader (default 64 x 1 table, byte beats).
// Define LUT_READBACK_EN to also exercise the readback stream.
module tb_lut_table_loader;

  logic       clk;
  logic       rst_n;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_data;
  logic       cfg_last;
  logic       lk_valid;
  logic       lk_ready;
  logic [5:0] lk_addr;
  logic       res_valid;
  logic [0:0] res_data;
  logic       table_ok;
  logic       cfg_err;
`ifdef LUT_READBACK_EN
  logic       rb_req;
  logic       rb_valid;
  logic [0:0] rb_data;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  lut_table_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .cfg_last  (cfg_last),
    .lk_valid  (lk_valid),
    .lk_ready  (lk_ready),
    .lk_addr   (lk_addr),
    .res_valid (res_valid),
    .res_data  (res_data),
    .table_ok  (table_ok),
`ifdef LUT_READBACK_EN
    .rb_req    (rb_req),
    .rb_valid  (rb_valid),
    .rb_data   (rb_data),
`endif
    .cfg_err   (cfg_err)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] time limit reached");
  end

  // Drive one beat from a negedge; it is taken on the following posedge
  task automatic send_beat(input logic [7:0] d, input logic last);
    cfg_valid = 1'b1;
    cfg_data  = d;
    cfg_last  = last;
    @(negedge clk);
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    cfg_data  = 8'h00;
  endtask

  // Full well-formed 8-beat load with the same byte in every beat
  task automatic load_table(input logic [7:0] d);
    for (int k = 0; k < 8; k++) send_beat(d, k == 7);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_data = 8'h00; cfg_last = 1'b0;
    lk_valid = 1'b0; lk_addr = 6'd0;
`ifdef LUT_READBACK_EN
    rb_req = 1'b0;
`endif
    repeat (2) @(negedge clk);
    n_checks++; if (cfg_ready !== 1'b0) $display("[TB] FAIL rst_cfg_ready: got %b expected 0", cfg_ready); else n_pass++;
    n_checks++; if (lk_ready !== 1'b0) $display("[TB] FAIL rst_lk_ready: got %b expected 0", lk_ready); else n_pass++;
    n_checks++; if (res_valid !== 1'b0) $display("[TB] FAIL rst_res_valid: got %b expected 0", res_valid); else n_pass++;
    n_checks++; if (res_data !== 1'b0) $display("[TB] FAIL rst_res_data: got %b expected 0", res_data); else n_pass++;
    n_checks++; if (table_ok !== 1'b0) $display("[TB] FAIL rst_table_ok: got %b expected 0", table_ok); else n_pass++;
    n_checks++; if (cfg_err !== 1'b0) $display("[TB] FAIL rst_cfg_err: got %b expected 0", cfg_err); else n_pass++;
`ifdef LUT_READBACK_EN
    n_checks++; if (rb_valid !== 1'b0) $display("[TB] FAIL rst_rb_valid: got %b expected 0", rb_valid); else n_pass++;
    n_checks++; if (rb_data !== 1'b0) $display("[TB] FAIL rst_rb_data: got %b expected 0", rb_data); else n_pass++;
`endif
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (cfg_ready !== 1'b1) $display("[TB] FAIL empty_cfg_ready: got %b expected 1", cfg_ready); else n_pass++;
    n_checks++; if (lk_ready !== 1'b0) $display("[TB] FAIL empty_lk_ready: got %b expected 0", lk_ready); else n_pass++;
  endtask

  // Table 0x0F per byte: entry e is 1 exactly when e%8 < 4
  task automatic test_load_and_lookup();
    for (int k = 0; k < 7; k++) send_beat(8'h0F, 1'b0);
    n_checks++; if (table_ok !== 1'b0) $display("[TB] FAIL t1_ok_before_last: got %b expected 0", table_ok); else n_pass++;
    send_beat(8'h0F, 1'b1);
    n_checks++; if (table_ok !== 1'b1) $display("[TB] FAIL t1_table_ok: got %b expected 1", table_ok); else n_pass++;
    n_checks++; if (lk_ready !== 1'b1) $display("[TB] FAIL t1_lk_ready: got %b expected 1", lk_ready); else n_pass++;
    n_checks++; if (cfg_err !== 1'b0) $display("[TB] FAIL t1_cfg_err: got %b expected 0", cfg_err); else n_pass++;
    lk_valid = 1'b1; lk_addr = 6'd3;
    @(negedge clk);
    lk_valid = 1'b0;
    n_checks++; if (res_valid !== 1'b1) $display("[TB] FAIL t1_res_valid_a3: got %b expected 1", res_valid); else n_pass++;
    n_checks++; if (res_data !== 1'b1) $display("[TB] FAIL t1_res_data_a3: got %b expected 1", res_data); else n_pass++;
    @(negedge clk);
    n_checks++; if (res_valid !== 1'b0) $display("[TB] FAIL t1_res_valid_pulse: got %b expected 0", res_valid); else n_pass++;
    lk_valid = 1'b1; lk_addr = 6'd4;
    @(negedge clk);
    lk_valid = 1'b0;
    n_checks++; if (res_valid !== 1'b1) $display("[TB] FAIL t1_res_valid_a4: got %b expected 1", res_valid); else n_pass++;
    n_checks++; if (res_data !== 1'b0) $display("[TB] FAIL t1_res_data_a4: got %b expected 0", res_data); else n_pass++;
    @(negedge clk);
  endtask

  // Early cfg_last on beat 5, then recovery with a 0xA5 table
  task automatic test_early_last();
    for (int k = 0; k < 6; k++) send_beat(8'h33, k == 5);
    n_checks++; if (cfg_err !== 1'b1) $display("[TB] FAIL t2_cfg_err: got %b expected 1", cfg_err); else n_pass++;
    n_checks++; if (table_ok !== 1'b0) $display("[TB] FAIL t2_table_ok: got %b expected 0", table_ok); else n_pass++;
    n_checks++; if (lk_ready !== 1'b0) $display("[TB] FAIL t2_lk_ready: got %b expected 0", lk_ready); else n_pass++;
    send_beat(8'hA5, 1'b0);
    n_checks++; if (cfg_err !== 1'b0) $display("[TB] FAIL t2_err_clear: got %b expected 0", cfg_err); else n_pass++;
    for (int k = 1; k < 8; k++) send_beat(8'hA5, k == 7);
    n_checks++; if (table_ok !== 1'b1) $display("[TB] FAIL t2_reload_ok: got %b expected 1", table_ok); else n_pass++;
    n_checks++; if (cfg_err !== 1'b0) $display("[TB] FAIL t2_reload_err: got %b expected 0", cfg_err); else n_pass++;
    // back-to-back lookups: addr 1 -> bit1 of A5 = 0, addr 61 -> bit5 = 1
    lk_valid = 1'b1; lk_addr = 6'd1;
    @(negedge clk);
    n_checks++; if ({res_valid, res_data} !== 2'b10) $display("[TB] FAIL t2_b2b_a1: got %b expected 10", {res_valid, res_data}); else n_pass++;
    lk_addr = 6'd61;
    @(negedge clk);
    lk_valid = 1'b0;
    n_checks++; if ({res_valid, res_data} !== 2'b11) $display("[TB] FAIL t2_b2b_a61: got %b expected 11", {res_valid, res_data}); else n_pass++;
    @(negedge clk);
  endtask

  // Eight beats without cfg_last; lookups held high must not be served
  task automatic test_missing_last();
    send_beat(8'h55, 1'b0);
    lk_valid = 1'b1; lk_addr = 6'd5;
    for (int k = 1; k < 8; k++) begin
      send_beat(8'h55, 1'b0);
      n_checks++; if ({res_valid, lk_ready} !== 2'b00) $display("[TB] FAIL t3_no_lookup_beat%0d: got %b expected 00", k, {res_valid, lk_ready}); else n_pass++;
    end
    n_checks++; if (cfg_err !== 1'b1) $display("[TB] FAIL t3_cfg_err: got %b expected 1", cfg_err); else n_pass++;
    n_checks++; if (table_ok !== 1'b0) $display("[TB] FAIL t3_table_ok: got %b expected 0", table_ok); else n_pass++;
    @(negedge clk);
    n_checks++; if (res_valid !== 1'b0) $display("[TB] FAIL t3_err_res_valid: got %b expected 0", res_valid); else n_pass++;
    lk_valid = 1'b0;
  endtask

  // Lookup and reload beat on the same edge see the old all-ones table
  task automatic test_same_cycle_reload();
    load_table(8'hFF);
    n_checks++; if (table_ok !== 1'b1) $display("[TB] FAIL t4_armed: got %b expected 1", table_ok); else n_pass++;
    lk_valid = 1'b1; lk_addr = 6'd63;
    send_beat(8'h00, 1'b0);
    lk_valid = 1'b0;
    n_checks++; if ({res_valid, res_data} !== 2'b11) $display("[TB] FAIL t4_old_table: got %b expected 11", {res_valid, res_data}); else n_pass++;
    n_checks++; if (lk_ready !== 1'b0) $display("[TB] FAIL t4_lk_ready_drop: got %b expected 0", lk_ready); else n_pass++;
    n_checks++; if (table_ok !== 1'b0) $display("[TB] FAIL t4_table_ok_drop: got %b expected 0", table_ok); else n_pass++;
    for (int k = 1; k < 8; k++) send_beat(8'h00, k == 7);
    lk_valid = 1'b1; lk_addr = 6'd63;
    @(negedge clk);
    lk_valid = 1'b0;
    n_checks++; if ({res_valid, res_data} !== 2'b10) $display("[TB] FAIL t4_new_table: got %b expected 10", {res_valid, res_data}); else n_pass++;
  endtask

  // Async reset after four reload beats, then a fresh 0x3C load
  task automatic test_reset_midload();
    for (int k = 0; k < 4; k++) send_beat(8'h33, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (table_ok !== 1'b0) $display("[TB] FAIL t5_table_ok: got %b expected 0", table_ok); else n_pass++;
    n_checks++; if ({cfg_ready, lk_ready, res_valid, cfg_err} !== 4'b0000) $display("[TB] FAIL t5_outputs: got %b expected 0000", {cfg_ready, lk_ready, res_valid, cfg_err}); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (cfg_ready !== 1'b1) $display("[TB] FAIL t5_cfg_ready: got %b expected 1", cfg_ready); else n_pass++;
    for (int k = 0; k < 7; k++) send_beat(8'h3C, 1'b0);
    n_checks++; if (table_ok !== 1'b0) $display("[TB] FAIL t5_ok_early: got %b expected 0", table_ok); else n_pass++;
    send_beat(8'h3C, 1'b1);
    n_checks++; if ({table_ok, cfg_err} !== 2'b10) $display("[TB] FAIL t5_reload: got %b expected 10", {table_ok, cfg_err}); else n_pass++;
    // 0x3C: addr 2 -> 1, addr 1 -> 0, addr 13 (bit5) -> 1
    lk_valid = 1'b1; lk_addr = 6'd2;
    @(negedge clk);
    n_checks++; if ({res_valid, res_data} !== 2'b11) $display("[TB] FAIL t5_a2: got %b expected 11", {res_valid, res_data}); else n_pass++;
    lk_addr = 6'd1;
    @(negedge clk);
    n_checks++; if ({res_valid, res_data} !== 2'b10) $display("[TB] FAIL t5_a1: got %b expected 10", {res_valid, res_data}); else n_pass++;
    lk_addr = 6'd13;
    @(negedge clk);
    lk_valid = 1'b0;
    n_checks++; if ({res_valid, res_data} !== 2'b11) $display("[TB] FAIL t5_a13: got %b expected 11", {res_valid, res_data}); else n_pass++;
    @(negedge clk);
  endtask

`ifdef LUT_READBACK_EN
  // Diagonal table (beat k = 1<<k): entry e is 1 only when e%8 == e/8
  task automatic test_readback();
    logic [7:0] beat;
    logic       exp_bit;
    int         bad;
    for (int k = 0; k < 8; k++) begin
      beat = 8'h01 << k;
      send_beat(beat, k == 7);
    end
    n_checks++; if ({table_ok, rb_valid} !== 2'b10) $display("[TB] FAIL t6_pre: got %b expected 10", {table_ok, rb_valid}); else n_pass++;
    rb_req = 1'b1;
    @(negedge clk);
    rb_req = 1'b0;
    bad = 0;
    for (int e = 0; e < 64; e++) begin
      exp_bit = ((e % 8) == (e / 8));
      n_checks++;
      if ({rb_valid, rb_data, cfg_ready, lk_ready} !== {1'b1, exp_bit, 2'b00}) begin
        $display("[TB] FAIL t6_rb_entry%0d: got %b expected %b", e, {rb_valid, rb_data, cfg_ready, lk_ready}, {1'b1, exp_bit, 2'b00});
        bad++;
      end else n_pass++;
      if (e == 0) rb_req = 1'b1;
      @(negedge clk);
      rb_req = 1'b0;
    end
    n_checks++; if ({rb_valid, cfg_ready, lk_ready} !== 3'b011) $display("[TB] FAIL t6_post: got %b expected 011", {rb_valid, cfg_ready, lk_ready}); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_load_and_lookup();
    test_early_last();
    test_missing_last();
    test_same_cycle_reload();
    test_reset_midload();
`ifdef LUT_READBACK_EN
    test_readback();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
